// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-and-add multiplier with a start/ready/valid handshake.
// Takes WIDTH-bit operands and returns a 2*WIDTH-bit product over WIDTH RUN cycles.
// Optional build macro: SEQ_MULT_SIGNED_EN, which selects two's-complement operands
// (sign-magnitude core with a final conditional negate).
// Without the macro the design is purely unsigned.
module seq_multiplier #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CNT_W-1:0]     cnt_r;

  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [2*WIDTH-1:0]   sum_s;
  logic [2*WIDTH-1:0]   result_s;

`ifdef SEQ_MULT_SIGNED_EN
  logic                 sign_r;

  // Magnitude of a two's-complement value; the most negative value maps to 2^(W-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      abs_val = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      abs_val = v;
    end
  endfunction

  // Operand magnitudes and sign-corrected final product.
  always_comb begin
    a_mag_s  = abs_val(a);
    b_mag_s  = abs_val(b);
    result_s = sum_s;
    if (sign_r) begin
      result_s = (~sum_s) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result_s = sum_s;
    end
  end

  // Result sign, captured with the operands on the accepted start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r <= 1'b0;
    end else if (state_r == IDLE && start) begin
      sign_r <= a[WIDTH-1] ^ b[WIDTH-1];
    end else begin
      sign_r <= sign_r;
    end
  end
`else
  // Unsigned build: operands pass straight through and the accumulator is the product.
  always_comb begin
    a_mag_s  = a;
    b_mag_s  = b;
    result_s = sum_s;
  end
`endif

  // Accumulator value after this RUN step (conditional add of the shifted multiplicand).
  always_comb begin
    sum_s = acc_r;
    if (mplier_r[0]) begin
      sum_s = acc_r + mcand_r;
    end else begin
      sum_s = acc_r;
    end
  end

  // Control FSM and datapath registers; every handshake output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      product  <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      valid    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
            mplier_r <= b_mag_s;
            acc_r    <= '0;
            cnt_r    <= '0;
            ready    <= 1'b0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end else begin
            ready    <= 1'b1;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        RUN: begin
          acc_r    <= sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            product <= result_s;
            busy    <= 1'b0;
            valid   <= 1'b1;
            state_r <= DONE;
          end else begin
            busy    <= 1'b1;
            valid   <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          // start is deliberately not looked at here: requests are never queued.
          valid   <= 1'b0;
          ready   <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          valid   <= 1'b0;
          ready   <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=4): a table of directed vectors,
// plus hand-written sequences for start-while-busy, reset mid-operation and
// an exhaustive back-to-back sweep.
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           valid;
  logic [2*W-1:0] product;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int vcount = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .valid   (valid),
    .product (product)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for valid-spacing checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Count valid pulses, sampled at the edge that ends each cycle.
  always @(posedge clk) if (valid === 1'b1) vcount <= vcount + 1;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One multiply with full handshake and latency checks; leaves us on a negedge.
  task automatic run_mult(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [2*W-1:0] exp, input string name);
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    for (int t = 0; t < 20 && ready !== 1'b1; t++) @(negedge clk);
    check({name, "_ready_pre"}, 64'(ready), 64'd1);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib;            // operands changing after the start edge must not matter
    for (int k = 0; k < W; k++) begin
      if (k > 0) @(negedge clk);
      if (busy === 1'b1 && valid === 1'b0) busy_cnt++;
    end
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    @(negedge clk);
    check({name, "_valid"}, 64'(valid), 64'd1);
    check({name, "_product"}, 64'(product), 64'(exp));
    @(negedge clk);
    check({name, "_valid_drop"}, 64'(valid), 64'd0);
    check({name, "_ready_back"}, 64'(ready), 64'd1);
    check({name, "_hold"}, 64'(product), 64'(exp));
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [2*W-1:0] p;
    p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
    return p;
`else
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int v0;
    int last_valid;
    logic [7:0] pair;

`ifdef SEQ_MULT_SIGNED_EN
    vecs.push_back('{4'h8, 4'h7, 8'hC8, "s_m8x7"});
    vecs.push_back('{4'h8, 4'h8, 8'h40, "s_m8xm8"});
    vecs.push_back('{4'h3, 4'hF, 8'hFD, "s_3xm1"});
    vecs.push_back('{4'h7, 4'h7, 8'h31, "s_7x7"});
    vecs.push_back('{4'hF, 4'hF, 8'h01, "s_m1xm1"});
    vecs.push_back('{4'h0, 4'hD, 8'h00, "s_zero"});
`else
    vecs.push_back('{4'd15, 4'd15, 8'd225, "max"});
    vecs.push_back('{4'd0,  4'd13, 8'd0,   "zero"});
    vecs.push_back('{4'd1,  4'd13, 8'd13,  "ident"});
    vecs.push_back('{4'd10, 4'd12, 8'd120, "10x12"});
    vecs.push_back('{4'd8,  4'd8,  8'd64,  "8x8"});
    vecs.push_back('{4'd7,  4'd9,  8'd63,  "7x9"});
    vecs.push_back('{4'd15, 4'd0,  8'd0,   "b_zero"});
    vecs.push_back('{4'd15, 4'd1,  8'd15,  "15x1"});
`endif

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) run_mult(vecs[i].va, vecs[i].vb, vecs[i].exp, vecs[i].name);

    // Start asserted during RUN must be dropped, not queued
    @(negedge clk);
    v0 = vcount;
    a = 4'd3; b = 4'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 4'd7; b = 4'd7;          // start still high while busy
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("ign_pulses", 64'(vcount - v0), 64'd1);
    check("ign_product", 64'(product), 64'(model(4'd3, 4'd5)));
    check("ign_ready", 64'(ready), 64'd1);

    // Reset in RUN cycle 2, together with start: reset wins, no valid pulse
    @(negedge clk);
    a = 4'd9; b = 4'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    v0 = vcount;
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_product", 64'(product), 64'd0);
    repeat (10) @(negedge clk);
    check("mid_rst_pulses", 64'(vcount - v0), 64'd0);
    check("mid_rst_product_hold", 64'(product), 64'd0);
    run_mult(4'd2, 4'd3, 8'd6, "after_rst");

    // Exhaustive, back-to-back with start held high
    @(negedge clk);
    v0 = vcount;
    last_valid = 0;
    for (int i = 0; i < 256; i++) begin
      pair = 8'(i);
      for (int t = 0; t < 20 && ready !== 1'b1; t++) @(negedge clk);
      check("exh_ready", 64'(ready), 64'd1);
      a = pair[7:4]; b = pair[3:0]; start = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 20 && valid !== 1'b1; t++) @(negedge clk);
      check("exh_valid", 64'(valid), 64'd1);
      check("exh_product", 64'(product), 64'(model(pair[7:4], pair[3:0])));
      if (i > 0) check("exh_spacing", 64'(cyc - last_valid), 64'(W + 2));
      last_valid = cyc;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("exh_pulse_count", 64'(vcount - v0), 64'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
